instr_encoder: RTL and testbench

- Packs field-level instruction requests (op class, funct, registers, immediate/offset) into 32-bit instruction words using the pipelined CPU's instruction format.
- Buffers the packed words in a small FIFO and streams them into instruction memory through a write handshake, using a wrapping word address.
- Sits between the host/loader and IMEM, and is the producer counterpart of the CPU decode stage.
- Illegal op/funct combinations are rejected and counted, so IMEM only ever receives legal instructions.

---
 rtl/instr_encoder.sv | 144 ++++++++++++++
 tb/tb_instr_encoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Field-level instruction packer with a small FIFO that streams legal words into IMEM.
// Optional macro INSTR_ENC_ILLEGAL_TRAP_EN: the first illegal request parks the block in TRAP.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AW        = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [5:0]    in_funct,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rn,
  input  logic [22:0]   in_src2,
  output logic          imem_we,
  input  logic          imem_ready,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          done,
  output logic [7:0]    err_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FullCnt = (PW + 1)'(DEPTH);
  localparam logic [AW-1:0] BaseAddr = AW'(BASE_ADDR);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRun   = 3'd1;
  localparam logic [2:0] StFlush = 3'd2;
  localparam logic [2:0] StDone  = 3'd3;
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
  localparam logic [2:0] StTrap  = 3'd4;
`endif

  logic [2:0]    state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic [AW-1:0] addr_q;
  logic [7:0]    err_q;

  logic        is_legal;
  logic [31:0] word;
  logic        accept, push, pop;

  always_comb begin
    is_legal = 1'b1;
    case (in_op)
      3'b011, 3'b111: is_legal = 1'b0;
      3'b000: begin
        case (in_funct[4:1])
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hC, 4'hD, 4'hF: is_legal = 1'b1;
          default: is_legal = 1'b0;
        endcase
      end
      default: is_legal = 1'b1;
    endcase
  end

  // Branches carry a full 23-bit offset in place of rn/rd/imm.
  always_comb begin
    if (in_op == 3'b010) begin
      word = {in_op, in_funct, in_src2};
    end else begin
      word = {in_op, in_funct, in_rn, in_rd, in_src2[12:0]};
    end
  end

  assign in_ready = (state_q == StRun) && (count_q != FullCnt);
  assign accept   = in_valid && in_ready;
  assign push     = accept && is_legal;
  assign imem_we  = (count_q != '0);
  assign pop      = imem_we && imem_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StRun;
    end else begin
      case (state_q)
        StRun: begin
          if (flush) state_d = StFlush;
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
          if (accept && !is_legal) state_d = StTrap;
`endif
        end
        StFlush: if (count_q == '0) state_d = StDone;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BaseAddr;
      err_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        addr_q   <= BaseAddr;
        err_q    <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          addr_q   <= addr_q + 1'b1;
        end
        count_q <= count_d;
        if (accept && !is_legal && (err_q != 8'hFF)) err_q <= err_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = imem_we ? mem_q[rd_ptr_q] : 32'h0;
  assign done       = (state_q == StDone);
  assign err_count  = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus queues expected IMEM writes, a monitor checks them.
module tb_instr_encoder;

  localparam int unsigned AW = 2;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n, start, flush, in_valid, in_ready;
  logic [2:0]    in_op;
  logic [5:0]    in_funct;
  logic [4:0]    in_rd, in_rn;
  logic [22:0]   in_src2;
  logic          imem_we, imem_ready;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          done;
  logic [7:0]    err_count;

  int n_cmp = 0;
  int n_err = 0;
  wr_t exp_q[$];
  logic [AW-1:0] exp_addr;

  instr_encoder #(
    .DEPTH    (4),
    .AW       (AW),
    .BASE_ADDR(0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_funct  (in_funct),
    .in_rd     (in_rd),
    .in_rn     (in_rn),
    .in_src2   (in_src2),
    .imem_we   (imem_we),
    .imem_ready(imem_ready),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .done      (done),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_addr = '0;
  endtask

  // Offer one request; queue its expected IMEM write when it should reach memory.
  task automatic send(input logic [2:0] op, input logic [5:0] f, input logic [4:0] rd,
                      input logic [4:0] rn, input logic [22:0] s2, input bit expect_wr,
                      input logic [31:0] exp_word);
    int n = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_funct = f;
    in_rd    = rd;
    in_rn    = rn;
    in_src2  = s2;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept", {31'b0, in_ready}, 32'd1);
    if (in_ready) begin
      tick();
      if (expect_wr) begin
        exp_q.push_back('{a: exp_addr, d: exp_word});
        exp_addr = exp_addr + 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  // Monitor: pops on every accepted IMEM write and checks stability while stalled.
  logic          stalled = 1'b0;
  logic [AW-1:0] prev_a;
  logic [31:0]   prev_d;
  always @(negedge clk) begin
    if (!rst_n || !imem_we) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_addr", 32'(imem_addr), 32'(prev_a));
        chk("stall_data", imem_wdata, prev_d);
      end
      if (imem_ready) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(imem_addr), 32'(e.a));
          chk("wr_data", imem_wdata, e.d);
        end
      end else begin
        stalled = 1'b1;
        prev_a  = imem_addr;
        prev_d  = imem_wdata;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; in_valid = 1'b0; imem_ready = 1'b1;
    in_op = '0; in_funct = '0; in_rd = '0; in_rn = '0; in_src2 = '0; exp_addr = '0;
    tick(); tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_we", {31'b0, imem_we}, 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", {31'b0, in_ready}, 32'd0);

    // Data-processing ADD and a branch whose rd/rn must not leak into the word.
    pulse_start();
    send(3'b000, 6'b001000, 5'd3, 5'd2, 23'd5, 1'b1, 32'h0408_6005);
    chk("first_we", {31'b0, imem_we}, 32'd1);
    send(3'b010, 6'b000000, 5'd31, 5'd31, 23'h7FFFFE, 1'b1, 32'h407F_FFFE);
    drain();

    // Backpressure: four words fill the FIFO and stay put until IMEM is ready.
    pulse_start();
    imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(3'b101, 6'b000001, 5'd1, 5'd1, 23'(k), 1'b1, 32'hA084_2000 + 32'(k));
    end
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    repeat (3) tick();
    imem_ready = 1'b1;
    drain();

    // Illegal requests handshake but never reach IMEM.
    pulse_start();
    chk("err_cleared", 32'(err_count), 32'd0);
    send(3'b011, 6'b000000, 5'd0, 5'd0, 23'd0, 1'b0, 32'h0);
    send(3'b000, 6'b001010, 5'd0, 5'd0, 23'd0, 1'b0, 32'h0);
    chk("illegal_no_we", {31'b0, imem_we}, 32'd0);
    chk("err_count2", 32'(err_count), 32'd2);
    send(3'b110, 6'b000000, 5'd0, 5'd0, 23'h7FFFFF, 1'b1, 32'hC000_1FFF);
    drain();

    // Address wrap at AW=2, then flush to DONE and restart.
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      send(3'b100, 6'b000000, 5'd0, 5'd0, 23'(k + 1), 1'b1, 32'h8000_0001 + 32'(k));
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    begin
      int n = 0;
      while (!done && n < 50) begin
        tick();
        n++;
      end
    end
    chk("flush_done", {31'b0, done}, 32'd1);
    chk("flush_drained", exp_q.size(), 32'd0);
    pulse_start();
    chk("restart_done", {31'b0, done}, 32'd0);
    chk("restart_addr", 32'(imem_addr), 32'd0);

    // Reset mid-stream drops queued words and clears the error count.
    imem_ready = 1'b0;
    send(3'b111, 6'b000000, 5'd0, 5'd0, 23'd0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      send(3'b001, 6'b000000, 5'd0, 5'd0, 23'(k), 1'b0, 32'h0);
    end
    chk("pre_rst_err", 32'(err_count), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_we", {31'b0, imem_we}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("mid_rst_err", 32'(err_count), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    imem_ready = 1'b1;
    repeat (5) tick();
    chk("final_queue", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
